fifo_packer: RTL and testbench

Width up-converter that sits directly upstream of the team's synchronous FIFO. It accepts narrow beats on a valid/ready stream, packs RATIO = OUT_WIDTH/IN_WIDTH beats into one word, and writes the word using the FIFO's push/full convention. A last flag closes a partial word early, with padding. Typical use: byte-wide peripheral receive paths (UART/SPI) feeding 32-bit FIFOs.

---
 rtl/fifo_packer_pkg.sv | 19 +
 rtl/fifo_packer_reg.sv | 21 ++
 rtl/fifo_packer.sv | 122 ++++++++++++
 tb/tb_fifo_packer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_packer_pkg.sv
// Shared types and helpers for the fifo_packer width up-converter.
// Lane fill-order mapping and the per-cycle packing event.
package fifo_packer_pkg;

   typedef enum logic [1:0] {
      EV_IDLE,
      EV_FILL,
      EV_CLOSE,
      EV_FLUSH
   } pack_ev_e;

   // Fill position of a physical lane; the mapping is its own inverse.
   function automatic int unsigned fill_pos(input int unsigned lane,
                                            input int unsigned ratio,
                                            input bit          msb_first);
      return msb_first ? (ratio - 1 - lane) : lane;
   endfunction

endpackage

// File: rtl/fifo_packer_reg.sv
// Reset-to-zero register with load enable, used for all fifo_packer state.
module fifo_packer_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_o <= '0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/fifo_packer.sv
// Packs RATIO narrow valid/ready beats into one wide word and writes it
// into a downstream FIFO using its push/full convention.
module fifo_packer
   import fifo_packer_pkg::*;
#(
   parameter int                  IN_WIDTH  = 8,
   parameter int                  OUT_WIDTH = 32,
   parameter bit                  MSB_FIRST = 1'b0,
   parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0,
   parameter int                  LOG_RATIO = $clog2(OUT_WIDTH / IN_WIDTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 flush_i,
   input  logic [IN_WIDTH-1:0]  in_dat_i,
   input  logic                 in_valid_i,
   input  logic                 in_last_i,
   output logic                 in_ready_o,
   output logic [OUT_WIDTH-1:0] dat_o,
   output logic                 push_o,
   input  logic                 full_i,
   output logic [LOG_RATIO-1:0] lane_cnt_o
);

   localparam int unsigned RATIO = OUT_WIDTH / IN_WIDTH;

   logic [OUT_WIDTH-1:0] acc_q, acc_d, merged, word, out_q;
   logic [LOG_RATIO-1:0] lane_q, lane_d;
   logic                 out_vld_q, out_vld_d;
   logic                 drain, slot_free, completes;
   pack_ev_e             ev;

   assign drain      = out_vld_q & ~full_i;
   assign slot_free  = ~out_vld_q | drain;
   assign completes  = (lane_q == LOG_RATIO'(RATIO - 1)) | in_last_i;
   assign in_ready_o = completes ? slot_free : 1'b1;

   assign push_o     = out_vld_q;
   assign dat_o      = out_q;
   assign lane_cnt_o = lane_q;

   always_comb begin
      ev = EV_IDLE;
      if (flush_i) begin
         ev = EV_FLUSH;
      end else if (in_valid_i && in_ready_o) begin
         ev = completes ? EV_CLOSE : EV_FILL;
      end
   end

   // merged keeps unfilled lanes as-is for the accumulator; word adds padding on early close.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      merged = acc_q;
      word   = acc_q;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (fill_pos(i, RATIO, MSB_FIRST) == 32'(lane_q)) begin
            merged[i*IN_WIDTH +: IN_WIDTH] = in_dat_i;
            word[i*IN_WIDTH +: IN_WIDTH]   = in_dat_i;
         end else if (in_last_i && (fill_pos(i, RATIO, MSB_FIRST) > 32'(lane_q))) begin
            word[i*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
         end
      end
   end

   always_comb begin
      acc_d     = acc_q;
      lane_d    = lane_q;
      out_vld_d = out_vld_q & ~drain;
      unique case (ev)
         EV_FLUSH: begin
            acc_d     = '0;
            lane_d    = '0;
            out_vld_d = 1'b0;
         end
         EV_FILL: begin
            acc_d  = merged;
            lane_d = lane_q + LOG_RATIO'(1);
         end
         EV_CLOSE: begin
            acc_d     = '0;
            lane_d    = '0;
            out_vld_d = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: the data registers are reset too, so dat_o reads zero and no stale lane survives a reset.
   fifo_packer_reg #(.WIDTH(OUT_WIDTH)) u_acc (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (ev != EV_IDLE),
      .d_i     (acc_d),
      .q_o     (acc_q)
   );

   fifo_packer_reg #(.WIDTH(LOG_RATIO)) u_lane (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (ev != EV_IDLE),
      .d_i     (lane_d),
      .q_o     (lane_q)
   );

   fifo_packer_reg #(.WIDTH(OUT_WIDTH)) u_out (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (ev == EV_CLOSE),
      .d_i     (word),
      .q_o     (out_q)
   );

   fifo_packer_reg #(.WIDTH(1)) u_out_vld (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (1'b1),
      .d_i     (out_vld_d),
      .q_o     (out_vld_q)
   );

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer: LSB-first and MSB-first instances share
// stimulus; a monitor pops expected words whenever a FIFO write happens.
module tb_fifo_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  in_dat = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        full = 1'b0;

   logic        rdy_lsb, rdy_msb, push_lsb, push_msb;
   logic [31:0] dat_lsb, dat_msb;
   logic [1:0]  lane_lsb, lane_msb;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_lsb_q[$];
   logic [31:0] exp_msb_q[$];

   always #5 clk = ~clk;

   fifo_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .MSB_FIRST(1'b0), .PAD_VALUE(8'h00)) u_lsb (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_dat_i(in_dat),
      .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(rdy_lsb),
      .dat_o(dat_lsb), .push_o(push_lsb), .full_i(full), .lane_cnt_o(lane_lsb)
   );

   fifo_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .MSB_FIRST(1'b1), .PAD_VALUE(8'h00)) u_msb (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_dat_i(in_dat),
      .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(rdy_msb),
      .dat_o(dat_msb), .push_o(push_msb), .full_i(full), .lane_cnt_o(lane_msb)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] w_lsb, input logic [31:0] w_msb);
      exp_lsb_q.push_back(w_lsb);
      exp_msb_q.push_back(w_msb);
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send_beat(input logic [7:0] d, input logic last);
      int waited = 0;
      in_valid = 1'b1;
      in_dat   = d;
      in_last  = last;
      @(negedge clk);
      while (!rdy_lsb && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 20) check("beat_accept_timeout", 64'(rdy_lsb), 64'd1);
      check("ready_agree", 64'(rdy_msb), 64'(rdy_lsb));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check({name, "_push_lsb"}, 64'(push_lsb), 64'd0);
      check({name, "_push_msb"}, 64'(push_msb), 64'd0);
      check({name, "_lane_lsb"}, 64'(lane_lsb), 64'd0);
      check({name, "_lane_msb"}, 64'(lane_msb), 64'd0);
   endtask

   // Monitor: a word is written into the FIFO whenever push & ~full.
   always @(negedge clk) begin
      if (rst_n && push_lsb && !full) begin
         if (exp_lsb_q.size() == 0) check("lsb_unexpected_push", 64'(push_lsb), 64'd0);
         else check("lsb_word", 64'(dat_lsb), 64'(exp_lsb_q.pop_front()));
      end
      if (rst_n && push_msb && !full) begin
         if (exp_msb_q.size() == 0) check("msb_unexpected_push", 64'(push_msb), 64'd0);
         else check("msb_word", 64'(dat_msb), 64'(exp_msb_q.pop_front()));
      end
   end

   initial begin
      #3;
      check_idle("reset");
      check("reset_dat_lsb", 64'(dat_lsb), 64'd0);
      check("reset_rdy_lsb", 64'(rdy_lsb), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full word, both lane orders.
      expect_word(32'h44332211, 32'h11223344);
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b0);
      send_beat(8'h33, 1'b0);
      send_beat(8'h44, 1'b0);
      @(posedge clk);
      #1;
      check_idle("after_word1");

      // Early close with padding.
      expect_word(32'h0000BBAA, 32'hAABB0000);
      send_beat(8'hAA, 1'b0);
      send_beat(8'hBB, 1'b1);
      check("pad_lane_cnt", 64'(lane_lsb), 64'd0);

      // Lone last beat.
      expect_word(32'h0000005A, 32'h5A000000);
      send_beat(8'h5A, 1'b1);

      // Back-to-back words at full throughput.
      expect_word(32'h04030201, 32'h01020304);
      expect_word(32'h08070605, 32'h05060708);
      for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
      @(posedge clk);
      #1;

      // Backpressure: pending word held, three beats accumulate, fourth stalls.
      full = 1'b1;
      expect_word(32'hD4D3D2D1, 32'hD1D2D3D4);
      expect_word(32'h04030201, 32'h01020304);
      send_beat(8'hD1, 1'b0);
      send_beat(8'hD2, 1'b0);
      send_beat(8'hD3, 1'b0);
      send_beat(8'hD4, 1'b0);
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      send_beat(8'h03, 1'b0);
      check("bp_lane_cnt", 64'(lane_lsb), 64'd3);
      check("bp_push_held", 64'(push_lsb), 64'd1);
      in_valid = 1'b1;
      in_dat   = 8'h04;
      @(negedge clk);
      check("bp_stall_rdy_lsb", 64'(rdy_lsb), 64'd0);
      check("bp_stall_rdy_msb", 64'(rdy_msb), 64'd0);
      check("bp_dat_stable", 64'(dat_lsb), 64'hD4D3D2D1);
      @(posedge clk);
      #1;
      full = 1'b0;
      @(negedge clk);
      check("bp_release_rdy", 64'(rdy_lsb), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_idle("after_bp");

      // Flush drops the partial word and the beat presented with it.
      send_beat(8'h99, 1'b0);
      send_beat(8'h9A, 1'b0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_dat   = 8'hEE;
      @(negedge clk);
      check("flush_rdy_unaffected", 64'(rdy_lsb), 64'd1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check_idle("after_flush");
      expect_word(32'h88776655, 32'h55667788);
      send_beat(8'h55, 1'b0);
      send_beat(8'h66, 1'b0);
      send_beat(8'h77, 1'b0);
      send_beat(8'h88, 1'b0);
      @(posedge clk);
      #1;

      // Asynchronous reset mid-word with a word pending.
      full = 1'b1;
      send_beat(8'hE1, 1'b0);
      send_beat(8'hE2, 1'b0);
      send_beat(8'hE3, 1'b0);
      send_beat(8'hE4, 1'b0);
      send_beat(8'hE5, 1'b0);
      check("pre_reset_push", 64'(push_lsb), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      check("async_reset_dat", 64'(dat_lsb), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      full  = 1'b0;
      check("post_reset_rdy_lsb", 64'(rdy_lsb), 64'd1);
      check("post_reset_rdy_msb", 64'(rdy_msb), 64'd1);

      // No stale lanes after reset.
      expect_word(32'h0000C2C1, 32'hC1C20000);
      send_beat(8'hC1, 1'b0);
      send_beat(8'hC2, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("lsb_queue_drained", 64'(exp_lsb_q.size()), 64'd0);
      check("msb_queue_drained", 64'(exp_msb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
